// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared access-size, response-cause and state types for riscv_lsu.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        MISALIGNED = 2'd1,
        BAD_SIZE   = 2'd2,
        TIMEOUT    = 2'd3
    } lsu_cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu_align
// Purpose  : Combinational byte-lane steering: store replication/strobes and
//            load lane shift with sign/zero extension.
// Revision : 1.0
// ============================================================================
module riscv_lsu_align
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  lsu_size_e                     i_size,
    input  logic                          i_store,
    input  logic                          i_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   i_off,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W-1:0]             i_rdata,
    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W/8-1:0]           o_wstrb,
    output logic [DATA_W-1:0]             o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0]     w_lane_mask;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_keep;
    logic              w_sign;

    always_comb begin
        o_wdata     = i_wdata;
        w_lane_mask = '1;
        case (i_size)
            BYTE: begin
                o_wdata     = {NB{i_wdata[7:0]}};
                w_lane_mask = NB'(1'b1);
            end
            HALF: begin
                o_wdata     = {(NB/2){i_wdata[15:0]}};
                w_lane_mask = NB'(2'b11);
            end
            WORD: begin
                o_wdata     = {(NB/4){i_wdata[31:0]}};
                w_lane_mask = NB'(4'hF);
            end
            default: begin
                o_wdata     = i_wdata;
                w_lane_mask = '1;
            end
        endcase
    end

    assign o_wstrb = i_store ? (w_lane_mask << i_off) : '0;

    // Move the addressed lane down to bit 0, then keep only the access width.
    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_keep = '1;
        w_sign = w_shift[DATA_W-1];
        case (i_size)
            BYTE: begin
                w_keep = DATA_W'(8'hFF);
                w_sign = w_shift[7];
            end
            HALF: begin
                w_keep = DATA_W'(16'hFFFF);
                w_sign = w_shift[15];
            end
            WORD: begin
                w_keep = DATA_W'(32'hFFFF_FFFF);
                w_sign = w_shift[31];
            end
            default: begin
                w_keep = '1;
                w_sign = w_shift[DATA_W-1];
            end
        endcase
    end

    assign o_rdata = (w_shift & w_keep) | ({DATA_W{w_sign & ~i_unsigned}} & ~w_keep);

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Purpose  : Single-outstanding load/store unit to a picorv32-style memory
//            port. Optional watchdog enabled by RISCV_LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic [1:0]           resp_cause,
    output logic                 busy,
    output logic                 mem_valid,
    output logic                 mem_instr,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W/8-1:0]  mem_wstrb,
    input  logic [DATA_W-1:0]    mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("riscv_lsu: DATA_W must be 32 or 64");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("riscv_lsu: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    lsu_state_e         r_state;
    lsu_state_e         w_next;
    logic               r_store;
    lsu_size_e          r_size;
    logic               r_unsigned;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    lsu_cause_e         r_cause;

    lsu_cause_e         w_fault;
    logic               w_accept;
    logic               w_expire;
    logic [DATA_W-1:0]  w_st_data;
    logic [DATA_W-1:0]  w_ld_data;
    logic [NB-1:0]      w_wstrb;

    assign w_accept = req_valid && (r_state == IDLE);

    // Size legality takes priority over alignment.
    always_comb begin
        w_fault = OK;
        if (req_size == 2'd3 && DATA_W == 32) begin
            w_fault = BAD_SIZE;
        end else begin
            case (req_size)
                2'd1:    if (req_addr[0])             w_fault = MISALIGNED;
                2'd2:    if (req_addr[1:0] != 2'b00)  w_fault = MISALIGNED;
                2'd3:    if (req_addr[2:0] != 3'b000) w_fault = MISALIGNED;
                default: w_fault = OK;
            endcase
        end
    end

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == MEM && !mem_ready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Counter holds the number of completed waiting cycles, so the last one is TIMEOUT_CYCLES-1.
    assign w_expire = (r_state == MEM) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = (w_fault != OK) ? RESP : MEM;
            MEM:     if (mem_ready || w_expire) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store    <= 1'b0;
            r_size     <= BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cause    <= OK;
        end else if (w_accept) begin
            r_store    <= req_store;
            r_size     <= lsu_size_e'(req_size);
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_cause    <= w_fault;
        end else if (r_state == MEM) begin
            if (mem_ready) begin
                if (!r_store) begin
                    r_rdata <= w_ld_data;
                end
            end else if (w_expire) begin
                r_cause <= TIMEOUT;
            end
        end
    end

    riscv_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size     (r_size),
        .i_store    (r_store),
        .i_unsigned (r_unsigned),
        .i_off      (r_addr[OFF_W-1:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .o_wdata    (w_st_data),
        .o_wstrb    (w_wstrb),
        .o_rdata    (w_ld_data)
    );

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign mem_valid  = (r_state == MEM);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_cause = r_cause;
    assign mem_instr  = 1'b0;
    assign mem_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_wdata  = w_st_data;
    assign mem_wstrb  = mem_valid ? w_wstrb : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Self-checking bench for riscv_lsu (32-bit and 64-bit instances).
// Revision : 1.0
// ============================================================================
module tb_riscv_lsu;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        req_valid, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, busy, mem_valid, mem_instr, mem_ready;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  resp_cause;
    logic [3:0]  mem_wstrb;

    // 64-bit instance
    logic        e_req_valid, e_req_store, e_req_unsigned;
    logic [1:0]  e_req_size;
    logic [31:0] e_req_addr;
    logic [63:0] e_req_wdata;
    logic        e_req_ready, e_resp_valid, e_busy, e_mem_valid, e_mem_instr, e_mem_ready;
    logic [63:0] e_resp_rdata, e_mem_wdata, e_mem_rdata;
    logic [31:0] e_mem_addr;
    logic [1:0]  e_resp_cause;
    logic [7:0]  e_mem_wstrb;

    riscv_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_cause(resp_cause), .busy(busy), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    riscv_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(255)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_store(e_req_store),
        .req_size(e_req_size), .req_unsigned(e_req_unsigned), .req_addr(e_req_addr),
        .req_wdata(e_req_wdata), .resp_valid(e_resp_valid), .resp_rdata(e_resp_rdata),
        .resp_cause(e_resp_cause), .busy(e_busy), .mem_valid(e_mem_valid),
        .mem_instr(e_mem_instr), .mem_ready(e_mem_ready), .mem_addr(e_mem_addr),
        .mem_wdata(e_mem_wdata), .mem_wstrb(e_mem_wstrb), .mem_rdata(e_mem_rdata)
    );

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        logic [1:0]  cause;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] mwd;
        logic [31:0] rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic un,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                                input int waits, input logic [1:0] cause, input logic [31:0] maddr,
                                input logic [3:0] wstrb, input logic [31:0] mwd, input logic [31:0] rdata);
        vec_t v;
        v.st = st; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd; v.rd = rd; v.waits = waits;
        v.cause = cause; v.maddr = maddr; v.wstrb = wstrb; v.mwd = mwd; v.rdata = rdata;
        return v;
    endfunction

    // Reference model: byte-oriented view of a 4-byte memory word.
    task automatic model(inout vec_t v);
        int nb;
        int off;
        logic [31:0] val;
        nb  = 1 << v.sz;
        off = int'(v.addr % 4);
        v.maddr = v.addr - off;
        if (v.sz == 2'd3)          v.cause = 2'd2;
        else if (v.addr % nb != 0) v.cause = 2'd1;
        else                       v.cause = 2'd0;
        v.wstrb = '0;
        v.mwd   = '0;
        val     = '0;
        v.rdata = '0;
        if (v.cause == 2'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (v.st && i >= off && i < off + nb) v.wstrb[i] = 1'b1;
                v.mwd[8*i +: 8] = v.wd[8*(i % nb) +: 8];
            end
            for (int k = 0; k < nb; k++) val[8*k +: 8] = v.rd[8*(off+k) +: 8];
            if (!v.un && nb < 4 && val[8*nb-1])
                for (int j = 8*nb; j < 32; j++) val[j] = 1'b1;
            v.rdata = v.st ? 32'd0 : val;
        end
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_store = v.st; req_size = v.sz; req_unsigned = v.un;
        req_addr = v.addr; req_wdata = v.wd;
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(negedge clk);
        // Garbage request held while busy must be ignored.
        req_store = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (v.cause != 2'd0) begin
            chk("fault_resp_valid", resp_valid, 1);
            chk("fault_cause", resp_cause, v.cause);
            chk("fault_rdata", resp_rdata, 0);
            chk("fault_mem_valid", mem_valid, 0);
            mem_ready = 1'($urandom % 2);
        end else begin
            mem_ready = 1'b0;
            chk("mem_valid", mem_valid, 1);
            chk("mem_addr", mem_addr, v.maddr);
            chk("mem_wstrb", mem_wstrb, v.wstrb);
            if (v.st) chk("mem_wdata", mem_wdata, v.mwd);
            chk("busy", busy, 1);
            chk("resp_valid_early", resp_valid, 0);
            for (int i = 0; i < v.waits; i++) begin
                mem_rdata = $urandom;
                @(negedge clk);
                chk("mem_hold_valid", mem_valid, 1);
                chk("mem_hold_addr", mem_addr, v.maddr);
                chk("mem_hold_wstrb", mem_wstrb, v.wstrb);
            end
            mem_ready = 1'b1;
            mem_rdata = v.rd;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            chk("resp_valid", resp_valid, 1);
            chk("resp_cause", resp_cause, 0);
            chk("resp_rdata", resp_rdata, v.rdata);
            chk("mem_valid_drop", mem_valid, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_pulse_end", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        mem_ready = 1'b0;
    endtask

    task automatic e_txn(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input logic [31:0] xaddr,
                         input logic [7:0] xstrb, input logic [63:0] xwd, input logic [63:0] xrd);
        @(negedge clk);
        e_req_valid = 1; e_req_store = st; e_req_size = sz; e_req_unsigned = un;
        e_req_addr = a; e_req_wdata = wd;
        @(negedge clk);
        e_req_valid = 0;
        chk("d64_mem_valid", e_mem_valid, 1);
        chk("d64_mem_addr", e_mem_addr, xaddr);
        chk("d64_mem_wstrb", e_mem_wstrb, xstrb);
        if (st) chk("d64_mem_wdata", e_mem_wdata, xwd);
        e_mem_ready = 1; e_mem_rdata = rd;
        @(negedge clk);
        e_mem_ready = 0;
        chk("d64_resp_valid", e_resp_valid, 1);
        chk("d64_resp_cause", e_resp_cause, 0);
        chk("d64_resp_rdata", e_resp_rdata, xrd);
    endtask

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;
        vec_t v;

        reset = 1;
        req_valid = 0; req_store = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        e_req_valid = 0; e_req_store = 0; e_req_size = 0; e_req_unsigned = 0; e_req_addr = 0;
        e_req_wdata = 0; e_mem_ready = 0; e_mem_rdata = 0;

        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_cause", resp_cause, 0);
        chk("rst_mem_instr", mem_instr, 0);
        @(negedge clk);
        reset = 0;

        //         st  sz  un  addr        wdata         rdata         w  cause maddr     strb  mwdata        rdata
        tbl[0]  = mk(1, 0, 0, 32'h1003, 32'h0000_00AB, 32'h0,         0, 0, 32'h1000, 4'h8, 32'hABAB_ABAB, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h2002, 32'h0,         32'h8001_1234, 0, 0, 32'h2000, 4'h0, 32'h0,         32'hFFFF_8001);
        tbl[2]  = mk(0, 1, 1, 32'h2002, 32'h0,         32'h8001_1234, 0, 0, 32'h2000, 4'h0, 32'h0,         32'h0000_8001);
        tbl[3]  = mk(0, 2, 0, 32'h3002, 32'h0,         32'h0,         0, 1, 32'h0,    4'h0, 32'h0,         32'h0);
        tbl[4]  = mk(0, 3, 0, 32'h4000, 32'h0,         32'h0,         0, 2, 32'h0,    4'h0, 32'h0,         32'h0);
        tbl[5]  = mk(1, 1, 0, 32'h1002, 32'h1234_5678, 32'h0,         0, 0, 32'h1000, 4'hC, 32'h5678_5678, 32'h0);
        tbl[6]  = mk(0, 0, 0, 32'h0011, 32'h0,         32'h0000_8000, 1, 0, 32'h0010, 4'h0, 32'h0,         32'hFFFF_FF80);
        tbl[7]  = mk(1, 2, 0, 32'h0020, 32'hDEAD_BEEF, 32'h0,         3, 0, 32'h0020, 4'hF, 32'hDEAD_BEEF, 32'h0);
        tbl[8]  = mk(1, 1, 0, 32'h0005, 32'h0,         32'h0,         0, 1, 32'h0,    4'h0, 32'h0,         32'h0);
        tbl[9]  = mk(0, 0, 1, 32'h0007, 32'h0,         32'hC300_0000, 2, 0, 32'h0004, 4'h0, 32'h0,         32'h0000_00C3);
        tbl[10] = mk(0, 2, 0, 32'h0040, 32'h0,         32'h89AB_CDEF, 0, 0, 32'h0040, 4'h0, 32'h0,         32'h89AB_CDEF);

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            v.st   = 1'($urandom);
            v.sz   = 2'($urandom);
            v.un   = 1'($urandom);
            v.addr = $urandom & 32'h0000_FFFF;
            if ($urandom % 4 != 0) v.addr = v.addr & ~((32'd1 << v.sz) - 1);
            v.wd    = $urandom;
            v.rd    = $urandom;
            v.waits = int'($urandom % 4);
            model(v);
            run_txn(v);
        end

        e_txn(0, 3, 0, 32'h8,  64'h0, 64'hDEADBEEF_CAFEF00D, 32'h8, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D);
        e_txn(1, 2, 0, 32'h4,  64'h11223344, 64'h0, 32'h0, 8'hF0, 64'h11223344_11223344, 64'h0);
        e_txn(0, 2, 0, 32'hC,  64'h0, 64'h89ABCDEF_00000000, 32'h8, 8'h00, 64'h0, 64'hFFFFFFFF_89ABCDEF);
        e_txn(1, 3, 0, 32'h10, 64'h01234567_89ABCDEF, 64'h0, 32'h10, 8'hFF, 64'h01234567_89ABCDEF, 64'h0);
        @(negedge clk);
        e_req_valid = 1; e_req_store = 0; e_req_size = 3; e_req_addr = 32'h4;
        @(negedge clk);
        e_req_valid = 0;
        chk("d64_fault_resp_valid", e_resp_valid, 1);
        chk("d64_fault_cause", e_resp_cause, 1);
        chk("d64_fault_mem_valid", e_mem_valid, 0);

        // Memory that never answers.
        @(negedge clk);
        req_valid = 1; req_store = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h100; mem_ready = 0;
        @(negedge clk);
        req_valid = 0;
`ifdef RISCV_LSU_TIMEOUT_EN
        cnt = 0;
        guard = 0;
        while (mem_valid && guard < 20) begin
            cnt++;
            guard++;
            @(negedge clk);
        end
        chk("timeout_mem_valid_cycles", cnt, 4);
        chk("timeout_resp_valid", resp_valid, 1);
        chk("timeout_cause", resp_cause, 3);
        chk("timeout_rdata", resp_rdata, 0);
        @(negedge clk);
        chk("timeout_resp_end", resp_valid, 0);
        @(negedge clk);
        req_valid = 1; req_store = 0; req_size = 2; req_addr = 32'h104;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("no_timeout_resp_count", cnt, 0);
`endif

        // Reset while the access is outstanding.
        chk("pre_reset_mem_valid", mem_valid, 1);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1;
        #1;
        chk("async_rst_mem_valid", mem_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_resp_valid", resp_valid, 0);
        chk("async_rst_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom % 2);
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        mem_ready = 0;
        chk("post_reset_no_resp", cnt, 0);
        run_txn(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
